// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder (serial_add).
package serial_add_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Bit counter width: clog2 of WIDTH, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell, shared with the parallel arithmetic blocks.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: latches operands on start, resolves one bit per
// clock LSB first through one full_adder_bit, then pulses done with
// {carryOut,sum} = a + b + carryIn.
// Optional macro SERIAL_ADD_SUB_EN adds port sub; sub=1 computes
// a - b - carryIn with carryOut acting as borrowOut.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sub_q, sub_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               sub_in;
    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_shift;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; a one-bit result register is just the bit.
    if (WIDTH == 1) begin : g_res_w1
        assign res_shift = fa_s;
    end else begin : g_res_wn
        assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state: load on accepted start, shift one bit per cycle in SHIFT.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + ~borrowIn; the final carry is inverted.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub_in}};
                    c_d     = carryIn ^ sub_in;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_cout;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_cout ^ sub_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryOut = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add (WIDTH=4). Define SERIAL_ADD_SUB_EN to
// also exercise the subtract mode.
module tb_serial_add;

    localparam int unsigned W     = 4;
    localparam int          LIMIT = 4 * W + 10;

    logic         clk;
    logic         rstN;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryIn;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryOut;

    int vectors    = 0;
    int miscompares = 0;

    logic [W:0] sb[$];

    serial_add #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryIn  (carryIn),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryOut (carryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic for {carryOut,sum} using wide integer math.
    function automatic logic [W:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                         input logic ci, input logic si);
        logic [W+1:0] wide;
        logic [W:0]   r;
        if (si) begin
            wide = {2'b00, ai} - {2'b00, bi} - {{(W+1){1'b0}}, ci};
            r    = {(({1'b0, ai}) < ({1'b0, bi} + {{W{1'b0}}, ci})), wide[W-1:0]};
        end else begin
            wide = {2'b00, ai} + {2'b00, bi} + {{(W+1){1'b0}}, ci};
            r    = wide[W:0];
        end
        return r;
    endfunction

    // Drive one start pulse and push the expected result.
    task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                            input logic ci, input logic si);
        a       = ai;
        b       = bi;
        carryIn = ci;
`ifdef SERIAL_ADD_SUB_EN
        sub     = si;
`endif
        start   = 1'b1;
        sb.push_back(model(ai, bi, ci, si));
        tick();
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        carryIn = $urandom;
    endtask

    // Wait (bounded) for done; cyc = cycles waited, -1 on timeout.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        int dones;
        rstN = 1'b0;
        repeat (3) begin
            a = $urandom; b = $urandom; carryIn = $urandom; start = $urandom;
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++;
        if (sum !== '0) begin miscompares++; $display("FAIL reset_sum got %0d want 0", sum); end
        vectors++;
        if (carryOut !== 1'b0) begin miscompares++; $display("FAIL reset_cout got %b want 0", carryOut); end
        start = 1'b0;
        rstN  = 1'b1;
        dones = 0;
        repeat (8) begin tick(); if (done) dones++; end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL idle_no_done got %0d pulses want 0", dones); end
    endtask

    task automatic test_add_basic();
        int cyc, bc;
        logic [W:0] exp;
        start_op(4'd5, 4'd4, 1'b1, 1'b0);
        wait_done(cyc, bc);
        exp = sb.pop_front();
        vectors++;
        if (cyc != W) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", cyc, W); end
        vectors++;
        if (bc != W) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, W); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
        vectors++;
        if ({carryOut, sum} !== exp) begin
            miscompares++; $display("FAIL basic_result got %0d/%0d want %0d/%0d", carryOut, sum, exp[W], exp[W-1:0]);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got %b want 0", done); end
        vectors++;
        if ({carryOut, sum} !== exp) begin
            miscompares++; $display("FAIL basic_hold got %0d/%0d want %0d/%0d", carryOut, sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_add_patterns();
        int cyc, bc;
        logic [W:0] exp;
        logic [W-1:0] av[2] = '{4'd10, 4'd15};
        logic [W-1:0] bv[2] = '{4'd12, 4'd0};
        logic         cv[2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            start_op(av[i], bv[i], cv[i], 1'b0);
            wait_done(cyc, bc);
            exp = sb.pop_front();
            vectors++;
            if ({carryOut, sum} !== exp || cyc != W) begin
                miscompares++;
                $display("FAIL pattern%0d got %0d/%0d lat %0d want %0d/%0d lat %0d",
                         i, carryOut, sum, cyc, exp[W], exp[W-1:0], W);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, extra;
        logic [W:0] exp;
        start_op(4'd3, 4'd6, 1'b0, 1'b0);
        tick();
        tick();
        a = 4'd1; b = 4'd1; carryIn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bc);
        exp = sb.pop_front();
        vectors++;
        if (cyc != 1) begin miscompares++; $display("FAIL ignore_latency got %0d want 1", cyc); end
        vectors++;
        if ({carryOut, sum} !== exp) begin
            miscompares++; $display("FAIL ignore_result got %0d/%0d want %0d/%0d", carryOut, sum, exp[W], exp[W-1:0]);
        end
        extra = 0;
        repeat (10) begin tick(); if (done || busy) extra++; end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL ignore_no_queue got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        logic [W:0] exp;
        start_op(4'd7, 4'd8, 1'b0, 1'b0);
        wait_done(cyc, bc);
        exp = sb.pop_front();
        vectors++;
        if ({carryOut, sum} !== exp) begin
            miscompares++; $display("FAIL b2b_first got %0d/%0d want %0d/%0d", carryOut, sum, exp[W], exp[W-1:0]);
        end
        start_op(4'd9, 4'd9, 1'b1, 1'b0);
        wait_done(cyc, bc);
        exp = sb.pop_front();
        vectors++;
        if (cyc < 0 || cyc + 1 != W + 1) begin
            miscompares++; $display("FAIL b2b_spacing got %0d want %0d", cyc + 1, W + 1);
        end
        vectors++;
        if ({carryOut, sum} !== exp) begin
            miscompares++; $display("FAIL b2b_second got %0d/%0d want %0d/%0d", carryOut, sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc, dones;
        logic [W:0] exp;
        start_op(4'd12, 4'd3, 1'b0, 1'b0);
        tick();
        tick();
        rstN = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if ({busy, done, carryOut, sum} !== '0) begin
            miscompares++; $display("FAIL midreset_clear got busy%b done%b %0d/%0d want all 0", busy, done, carryOut, sum);
        end
        tick();
        rstN  = 1'b1;
        dones = 0;
        repeat (8) begin tick(); if (done) dones++; end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL midreset_no_done got %0d want 0", dones); end
        start_op(4'd6, 4'd7, 1'b1, 1'b0);
        wait_done(cyc, bc);
        exp = sb.pop_front();
        vectors++;
        if ({carryOut, sum} !== exp || cyc != W) begin
            miscompares++; $display("FAIL midreset_fresh got %0d/%0d lat %0d want %0d/%0d lat %0d",
                                    carryOut, sum, cyc, exp[W], exp[W-1:0], W);
        end
    endtask

    task automatic test_random();
        int cyc, bc;
        logic [W:0] exp;
        logic si;
        for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            si = $urandom;
`else
            si = 1'b0;
`endif
            start_op(W'($urandom), W'($urandom), 1'($urandom), si);
            wait_done(cyc, bc);
            exp = sb.pop_front();
            vectors++;
            if ({carryOut, sum} !== exp) begin
                miscompares++; $display("FAIL random%0d got %0d/%0d want %0d/%0d", i, carryOut, sum, exp[W], exp[W-1:0]);
            end
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int cyc, bc;
        logic [W:0] exp;
        logic [W-1:0] av[3] = '{4'd2, 4'd11, 4'd5};
        logic [W-1:0] bv[3] = '{4'd4, 4'd2, 4'd5};
        logic         cv[3] = '{1'b0, 1'b1, 1'b1};
        logic [W:0]   fixed[3] = '{5'b1_1110, 5'b0_1000, 5'b1_1111};
        for (int i = 0; i < 3; i++) begin
            start_op(av[i], bv[i], cv[i], 1'b1);
            wait_done(cyc, bc);
            exp = sb.pop_front();
            vectors++;
            if ({carryOut, sum} !== fixed[i] || exp !== fixed[i] || cyc != W) begin
                miscompares++;
                $display("FAIL sub%0d got %0d/%0d lat %0d want %0d/%0d lat %0d",
                         i, carryOut, sum, cyc, fixed[i][W], fixed[i][W-1:0], W);
            end
        end
    endtask
`endif

    initial begin
        rstN    = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryIn = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub     = 1'b0;
`endif
        #1;
        test_reset();
        test_add_basic();
        test_add_patterns();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Bit-serial ripple adder: the addition-side counterpart of the team's 4-bit parallel subtractor (ports a, b, borrowIn, diff, borrowOut).
- Latches two WIDTH-bit operands and a carry on a start pulse, then resolves one bit per clock, LSB first, through a single full-adder cell.
- Reports sum and carry-out with a one-cycle done pulse.
- Serves as the area-lean arithmetic unit paired with the parallel subtractor in the datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepted start
- b  input  WIDTH  operand B, captured on the accepted start
- carryIn  input  1  carry into bit 0, captured on the accepted start
- busy  output  1  high while bits are being resolved
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result, held until the next completion
- carryOut  output  1  carry out of the MSB, held with sum

Behaviour:
- Clock and reset: single clock domain clk; reset is asynchronous, active-low (rstN).
- While rstN=0: state=IDLE; busy, done, sum, carryOut, internal shift registers and bit counter are all 0.
- FSM states: IDLE, SHIFT.
  - IDLE → SHIFT on the edge sampling start=1. That edge loads the A/B shift registers from a/b, the carry flop from carryIn and cnt=0.
  - In SHIFT, each edge computes s = A[0]^B[0]^c and c' = majority(A[0],B[0],c).
  - s shifts into the MSB of the result register; A and B shift right; cnt increments.
  - On the edge where cnt==WIDTH-1, the final bit is written. At that same edge: sum←completed result register, carryOut←c', done←1, busy←0, state←IDLE.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(WIDTH). For WIDTH=4, done is seen 4 edges after start.
- busy is registered: high from E0 through E(WIDTH); low in the same cycle done is high.
- done is high exactly one cycle per operation; it is never asserted without a preceding accepted start.
- start while busy=1: ignored. The operation in flight is unaffected and no request is queued.
- start high in the done cycle: accepted, since state is IDLE. Back-to-back operations therefore run every WIDTH+1 cycles.
- a, b and carryIn may change freely after the accepting edge.
- sum/carryOut change only on a completing edge or reset; they hold between operations.
- Arithmetic: {carryOut,sum} = a + b + carryIn, exact, (WIDTH+1) bits. For example, a=15, b=0, carryIn=1 wraps to sum=0, carryOut=1.
- Reset mid-operation: all state is cleared immediately, the operation is abandoned and no done pulse follows.
- WIDTH=1: a single SHIFT cycle; done one edge after start.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1: B is complemented at load, the loaded carry is ~carryIn (carryIn then acts as borrowIn), and the final carry is inverted into carryOut (borrowOut).
  - Result: sum = (a - b - carryIn) mod 2^WIDTH; carryOut=1 iff a < b+carryIn.
  - Convention matches the parallel subtractor's diff/borrowOut.
  - sub=0: identical to the base behaviour.
- Undefined: no sub port; add only. Cycle timing is identical in both builds.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, SHIFT}
  - default WIDTH constant
  - counter-width function (clog2 of WIDTH, min 1)
- Sub-module full_adder_bit (a, b, cin → s, cout): purely combinational, one instance. The parallel blocks also use it.

Test Plan:
- Reset: hold rstN=0 with random inputs → busy=0, done=0, sum=0, carryOut=0. Release; no done without start.
- a=5, b=4, carryIn=1, start pulse → busy for 4 cycles, then done for one cycle with sum=10, carryOut=0.
- a=10, b=12, carryIn=0 → sum=6, carryOut=1. Then a=15, b=0, carryIn=1 → sum=0, carryOut=1 (wrap).
- Re-pulse start 2 cycles into an op with a=1, b=1 → ignored; original result is delivered. Start asserted in the done cycle → next done exactly 5 cycles later.
- rstN pulsed low 2 edges into an op → outputs 0, no done. A fresh start afterwards completes correctly.
- With SERIAL_ADD_SUB_EN, sub=1:
  - a=2, b=4, carryIn=0 → sum=14, carryOut=1
  - a=11, b=2, carryIn=1 → sum=8, carryOut=0
  - a=5, b=5, carryIn=1 → sum=15, carryOut=1
